// File: rtl/dds_glide_osc_if.sv
// Bus bundle for the glide DDS oscillator.
// Stimulus side drives tick/target/gate/waveform; oscillator drives state and samples.
interface dds_glide_osc_if #(
  parameter int OUT_W = 12
);
  logic             sample_en;
  logic [31:0]      adder;
  logic             gate;
  logic [1:0]       wave_sel;
  logic [31:0]      phase;
  logic [31:0]      inc;
  logic [OUT_W-1:0] sample;
  logic             sample_vld;
  logic             sync;

  modport master (
    output sample_en, adder, gate, wave_sel,
    input  phase, inc, sample, sample_vld, sync
  );

  modport slave (
    input  sample_en, adder, gate, wave_sel,
    output phase, inc, sample, sample_vld, sync
  );
endinterface

// File: rtl/dds_glide_osc.sv
// Phase-accumulator oscillator with saw/square/triangle output.
// Define DDS_GLIDE_OSC_GLIDE_EN to slew inc toward adder (portamento).
module dds_glide_osc #(
  parameter int OUT_W       = 12,
  parameter int GLIDE_SHIFT = 8
) (
  input logic           clk,
  input logic           rst_n,
  dds_glide_osc_if.slave io
);
  localparam logic [OUT_W-1:0] MID = {1'b1, {(OUT_W-1){1'b0}}};

  logic [31:0]      phase_q, phase_d;
  logic [31:0]      inc_q, inc_d;
  logic [OUT_W-1:0] sample_q, sample_d;
  logic             vld_q, sync_q, sync_d;
  logic             gate_q, tick_q, rise;
  logic [32:0]      sum;

  assign rise = io.gate & ~gate_q;
  assign sum  = {1'b0, phase_q} + {1'b0, inc_q};

  always_comb begin
    phase_d = phase_q;
    sync_d  = 1'b0;
    if (io.sample_en) begin
      if (io.gate & ~rise) begin
        phase_d = sum[31:0];
        sync_d  = sum[32];
      end else begin
        phase_d = '0;
      end
    end
  end

`ifdef DDS_GLIDE_OSC_GLIDE_EN
  logic [32:0]        diff;
  logic signed [32:0] delta;

  assign diff  = {1'b0, io.adder} - {1'b0, inc_q};
  assign delta = $signed(diff) >>> GLIDE_SHIFT;

  // Fresh notes jump straight to pitch; otherwise slew, snapping once close.
  always_comb begin
    inc_d = inc_q;
    if (io.sample_en) begin
      if (inc_q == '0 || rise || delta == '0)
        inc_d = io.adder;
      else
        inc_d = inc_q + delta[31:0];
    end
  end
`else
  always_comb begin
    inc_d = inc_q;
    if (io.sample_en)
      inc_d = io.adder;
  end
`endif

  // Evaluated the cycle after a tick, so phase_q is the freshly updated phase.
  always_comb begin
    sample_d = MID;
    if (gate_q) begin
      unique case (io.wave_sel)
        2'b00:   sample_d = phase_q[31 -: OUT_W];
        2'b01:   sample_d = {OUT_W{phase_q[31]}};
        2'b10:   sample_d = phase_q[31] ? ~phase_q[30 -: OUT_W]
                                        :  phase_q[30 -: OUT_W];
        default: sample_d = MID;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q  <= '0;
      inc_q    <= '0;
      sample_q <= MID;
      vld_q    <= 1'b0;
      sync_q   <= 1'b0;
      gate_q   <= 1'b0;
      tick_q   <= 1'b0;
    end else begin
      phase_q <= phase_d;
      inc_q   <= inc_d;
      sync_q  <= sync_d;
      tick_q  <= io.sample_en;
      vld_q   <= tick_q;
      if (io.sample_en)
        gate_q <= io.gate;
      if (tick_q)
        sample_q <= sample_d;
    end
  end

  assign io.phase      = phase_q;
  assign io.inc        = inc_q;
  assign io.sample     = sample_q;
  assign io.sample_vld = vld_q;
  assign io.sync       = sync_q;
endmodule
